// File: rtl/alu_pkg.sv
// Shared widths, ALU function codes and sequencer state encoding for the ALU issue stage.
package alu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREGS = 8;
  localparam int DEF_FW    = 4;
  localparam int DEF_ZW    = 4;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: two async read ports, writeback port beats host port on a shared target.
// Entry 0 is never written and always reads as zero.
module alu_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             host_en,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_data
);

  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      // Both ports may land on the same edge at different entries; only a shared target is arbitrated.
      for (int i = 1; i < NREGS; i++) begin
        if (wb_en && wb_addr == AW'(i))
          mem[i] <= wb_data;
        else if (host_en && host_addr == AW'(i))
          mem[i] <= host_data;
      end
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Issue stage for an external combinational ALU: IDLE accepts a command, EXEC lets the ALU settle
// and writes back, RESP holds the result until consumed. No overlap, so at least 3 cycles per command.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int FW    = DEF_FW,
  parameter int ZW    = DEF_ZW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [FW-1:0]            cmd_f,
  input  logic [$clog2(NREGS)-1:0] cmd_rs1,
  input  logic [$clog2(NREGS)-1:0] cmd_rs2,
  input  logic                     cmd_imm_sel,
  input  logic [WIDTH-1:0]         cmd_imm,
  input  logic [$clog2(NREGS)-1:0] cmd_rd,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [FW-1:0]            alu_f,
  input  logic [WIDTH-1:0]         alu_y,
  input  logic [ZW-1:0]            alu_zero,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_y,
  output logic [ZW-1:0]            res_zero,
  output logic [$clog2(NREGS)-1:0] res_rd
);

  localparam int AW = $clog2(NREGS);

  state_t           state;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;

  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == RESP);

  // Operands are read at the accept edge with no bypass from a concurrent host write.
  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .ra1       (cmd_rs1),
    .ra2       (cmd_rs2),
    .rd1       (rf_a),
    .rd2       (rf_b),
    .wb_en     (state == EXEC),
    .wb_addr   (rd_q),
    .wb_data   (alu_y),
    .host_en   (wr_en),
    .host_addr (wr_addr),
    .host_data (wr_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_f    <= '0;
      rd_q     <= '0;
      res_y    <= '0;
      res_zero <= '0;
      res_rd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a <= rf_a;
            alu_b <= cmd_imm_sel ? cmd_imm : rf_b;
            alu_f <= cmd_f;
            rd_q  <= cmd_rd;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_y    <= alu_y;
          res_zero <= alu_zero;
          res_rd   <= rd_q;
          state    <= RESP;
        end
        RESP: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer with a behavioural ALU, register model and result scoreboard.
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_f = '0;
  logic [2:0]  cmd_rs1 = '0;
  logic [2:0]  cmd_rs2 = '0;
  logic        cmd_imm_sel = 1'b0;
  logic [W-1:0] cmd_imm = '0;
  logic [2:0]  cmd_rd = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] alu_a, alu_b, alu_y, res_y;
  logic [3:0]  alu_f, alu_zero, res_zero;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [2:0]  res_rd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] y;
    logic [3:0]   z;
    logic [2:0]   rd;
  } exp_t;
  exp_t exp_q[$];

  logic [W-1:0] mr [8];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] f);
    case (f)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      default: return a;
    endcase
  endfunction

  function automatic logic [3:0] zero_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] f);
    logic [W-1:0] y;
    y = alu_fn(a, b, f);
    return {a == b, ^y, y[W-1], y == '0};
  endfunction

  assign alu_y    = alu_fn(alu_a, alu_b, alu_f);
  assign alu_zero = zero_fn(alu_a, alu_b, alu_f);

  alu_operand_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_f       (cmd_f),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_imm_sel (cmd_imm_sel),
    .cmd_imm     (cmd_imm),
    .cmd_rd      (cmd_rd),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_f       (alu_f),
    .alu_y       (alu_y),
    .alu_zero    (alu_zero),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_y       (res_y),
    .res_zero    (res_zero),
    .res_rd      (res_rd)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a result is consumed on any edge where valid and ready are both high.
  always @(negedge clk) begin
    if (reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_y", res_y, e.y);
        chk("res_zero", {28'd0, res_zero}, {28'd0, e.z});
        chk("res_rd", {29'd0, res_rd}, {29'd0, e.rd});
      end
    end
  end

  task automatic host_wr(input logic [2:0] addr, input logic [W-1:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(posedge clk);
    if (addr != 0) mr[addr] = data;
    #1 wr_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] f, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic sel, input logic [W-1:0] imm, input logic [2:0] rd,
                       input int stall,
                       input logic hwa_en, input logic [2:0] hwa_addr, input logic [W-1:0] hwa_data,
                       input logic hwe_en, input logic [2:0] hwe_addr, input logic [W-1:0] hwe_data);
    logic [W-1:0] a, b, y;
    logic [3:0]   z;
    cmd_valid = 1'b1; cmd_f = f; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm_sel = sel; cmd_imm = imm; cmd_rd = rd;
    wr_en = hwa_en; wr_addr = hwa_addr; wr_data = hwa_data;
    res_ready = (stall == 0);
    @(negedge clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    a = mr[rs1];
    b = sel ? imm : mr[rs2];
    y = alu_fn(a, b, f);
    z = zero_fn(a, b, f);
    if (hwa_en && hwa_addr != 0) mr[hwa_addr] = hwa_data;
    #1;
    cmd_valid = 1'b0; cmd_f = 4'($urandom);
    wr_en = hwe_en; wr_addr = hwe_addr; wr_data = hwe_data;
    @(negedge clk);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_f", {28'd0, alu_f}, {28'd0, f});
    chk("exec_res_valid", {31'd0, res_valid}, 32'd0);
    chk("exec_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    if (hwe_en && hwe_addr != 0) mr[hwe_addr] = hwe_data;
    if (rd != 0) mr[rd] = y;
    exp_q.push_back('{y: y, z: z, rd: rd});
    #1;
    wr_en = 1'b0;
    // Stray commands during RESP must be ignored.
    cmd_valid = 1'b1; cmd_rs1 = 3'($urandom); cmd_rd = 3'($urandom); cmd_imm = $urandom;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_res_valid", {31'd0, res_valid}, 32'd1);
      chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("stall_res_y", res_y, y);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("res_valid_latency", {31'd0, res_valid}, 32'd1);
    chk("alu_a_hold", alu_a, a);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] f, input logic [2:0] rs1, input logic [2:0] rs2,
                     input logic sel, input logic [W-1:0] imm, input logic [2:0] rd);
    issue(f, rs1, rs2, sel, imm, rd, 0, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
  endtask

  task automatic read_reg(input logic [2:0] r);
    cmd(ALU_ADD, r, 3'd0, 1'b1, '0, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]   rf;
    logic [2:0]   ra, rb, rdst, ha, he;
    logic         rs, hae, hee;
    logic [W-1:0] ri, hd, hed;
    int           st;

    for (int i = 0; i < 8; i++) mr[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset mid-RESP aborts the result and clears all state.
    host_wr(3'd1, 32'h1234_5678);
    cmd_valid = 1'b1; cmd_f = ALU_ADD; cmd_rs1 = 3'd1; cmd_rs2 = 3'd1;
    cmd_imm_sel = 1'b0; cmd_rd = 3'd2; res_ready = 1'b0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) mr[i] = '0;
    @(negedge clk);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_f", {28'd0, alu_f}, 32'd0);
    chk("rst_res_y", res_y, 32'd0);
    chk("rst_res_zero", {28'd0, res_zero}, 32'd0);
    chk("rst_res_rd", {29'd0, res_rd}, 32'd0);
    @(posedge clk); #1;
    for (int r = 1; r < 8; r++) read_reg(3'(r));

    // Basic register add.
    host_wr(3'd1, 32'h0000_0005);
    host_wr(3'd2, 32'h0000_0003);
    cmd(ALU_ADD, 3'd1, 3'd2, 1'b0, '0, 3'd3);
    chk("add_model_r3", mr[3], 32'h0000_0008);
    read_reg(3'd3);

    // Writes to r0 are discarded.
    cmd(ALU_ADD, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF, 3'd0);
    read_reg(3'd0);

    // Consumer stall.
    issue(ALU_XOR, 3'd1, 3'd2, 1'b0, '0, 3'd4, 5, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
    read_reg(3'd4);

    // Writeback beats host write to the same register; accept-edge host write is not bypassed.
    issue(ALU_ADD, 3'd1, 3'd2, 1'b0, '0, 3'd3, 0, 1'b0, 3'd0, '0, 1'b1, 3'd3, 32'hDEAD_BEEF);
    read_reg(3'd3);
    issue(ALU_OR, 3'd1, 3'd0, 1'b1, 32'h0000_0100, 3'd5, 0, 1'b1, 3'd1, 32'hCAFE_0001, 1'b0, 3'd0, '0);
    read_reg(3'd1);
    read_reg(3'd5);

    // Equal-operand subtract.
    host_wr(3'd1, 32'd7);
    host_wr(3'd2, 32'd7);
    cmd(ALU_SUB, 3'd1, 3'd2, 1'b0, '0, 3'd6);
    chk("sub_model_zero", mr[6], 32'd0);

    // Random back-to-back commands with occasional host writes and stalls.
    for (int n = 0; n < 20; n++) begin
      rf   = 4'($urandom_range(0, 15));
      ra   = 3'($urandom);
      rb   = 3'($urandom);
      rdst = 3'($urandom);
      rs   = 1'($urandom);
      ri   = $urandom;
      st   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      hae  = ($urandom_range(0, 2) == 0);
      ha   = 3'($urandom);
      hd   = $urandom;
      hee  = ($urandom_range(0, 2) == 0);
      he   = 3'($urandom);
      hed  = $urandom;
      issue(rf, ra, rb, rs, ri, rdst, st, hae, ha, hd, hee, he, hed);
    end
    for (int r = 0; r < 8; r++) read_reg(3'(r));

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
